// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding, memory command.
// Also holds the data-port request error rule so every user applies the same check.
package mem_arb_pkg;

    localparam int MEM_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic             wr;
        logic [MEM_W-1:0] addr;
        logic [MEM_W-1:0] wdata;
    } memCmd_t;

    // Read and write at once, or any unaligned data access, is refused.
    function automatic logic dataReqErr(input logic rd, input logic wr, input logic [MEM_W-1:0] addr);
        return (rd & wr) | ((rd | wr) & addr[0]);
    endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement and the count holds at zero.
// New value visible the cycle after load/decrement; no backpressure.
module mem_arb_lat_cnt #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between fetch and data ports, data first; done fires MEM_LAT cycles after accept.
// Non-winners stall until their own done; optional MEM_ARB_STARVE_GUARD_EN forces fetch after STARVE_MAX data wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [MEM_W-1:0] i_addr,
    output logic [MEM_W-1:0] i_rdata,
    output logic             i_done,
    output logic             i_stall,
    input  logic             d_rd,
    input  logic             d_wr,
    input  logic [MEM_W-1:0] d_addr,
    input  logic [MEM_W-1:0] d_wdata,
    output logic [MEM_W-1:0] d_rdata,
    output logic             d_done,
    output logic             d_stall,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [MEM_W-1:0] mem_addr,
    output logic [MEM_W-1:0] mem_wdata,
    input  logic [MEM_W-1:0] mem_rdata,
    output logic             err
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arbState_t state, stateNxt;
    memCmd_t   cmdQ, winCmd, cmdOut;
    owner_t    winner;
    logic      accept, dReq, dErr, dOk, forceI, cntZero;
    logic      memEn, iDone, dDone;

    assign dReq = d_rd | d_wr;
    assign dErr = dataReqErr(d_rd, d_wr, d_addr);
    assign dOk  = dReq & ~dErr;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starveCnt;

    assign forceI = i_req & (starveCnt >= SW'(STARVE_MAX));

    // Counts data wins taken while fetch was waiting; any fetch win clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (accept) begin
            if (winner == OWN_I) begin
                starveCnt <= '0;
            end else if (i_req && (starveCnt < SW'(STARVE_MAX))) begin
                starveCnt <= starveCnt + SW'(1);
            end
        end
    end
`else
    // Strict data priority: fetch is never forced, STARVE_MAX has no effect.
    assign forceI = 1'b0 & (STARVE_MAX > 0);
`endif

    always_comb begin
        accept = 1'b0;
        winner = OWN_D;
        if (!rst && (state == IDLE)) begin
            if (forceI) begin
                accept = 1'b1;
                winner = OWN_I;
            end else if (dOk) begin
                accept = 1'b1;
                winner = OWN_D;
            end else if (i_req) begin
                accept = 1'b1;
                winner = OWN_I;
            end
        end
    end

    always_comb begin
        winCmd = '0;
        if (winner == OWN_D) begin
            winCmd.wr    = d_wr;
            winCmd.addr  = d_addr;
            winCmd.wdata = d_wdata;
        end else begin
            winCmd.addr  = i_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmdQ  <= '0;
        end else begin
            state <= stateNxt;
            if (accept) begin
                cmdQ <= winCmd;
            end
        end
    end

    // Done goes only to a port still requesting; an abandoned access finishes silently.
    always_comb begin
        stateNxt = state;
        memEn    = 1'b0;
        cmdOut   = '0;
        iDone    = 1'b0;
        dDone    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    memEn    = 1'b1;
                    cmdOut   = winCmd;
                    stateNxt = (winner == OWN_I) ? IBUSY : DBUSY;
                end
            end
            IBUSY: begin
                cmdOut = cmdQ;
                if (cntZero) begin
                    iDone    = i_req;
                    stateNxt = IDLE;
                end
            end
            DBUSY: begin
                cmdOut = cmdQ;
                if (cntZero) begin
                    dDone    = dReq;
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    mem_arb_lat_cnt #(
        .WIDTH (CNT_W)
    ) u_latCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .loadVal (CNT_W'(MEM_LAT - 1)),
        .dec     (state != IDLE),
        .zero    (cntZero)
    );

    assign mem_en    = memEn;
    assign mem_wr    = ~rst & cmdOut.wr;
    assign mem_addr  = rst ? '0 : cmdOut.addr;
    assign mem_wdata = rst ? '0 : cmdOut.wdata;

    assign i_done  = ~rst & iDone;
    assign d_done  = ~rst & dDone;
    assign i_rdata = i_done ? mem_rdata : '0;
    assign d_rdata = (d_done & ~cmdQ.wr) ? mem_rdata : '0;
    assign i_stall = ~rst & i_req & ~iDone;
    assign d_stall = ~rst & dReq & ~dDone;
    assign err     = ~rst & dErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level schedule model and a reference memory.
module tb_mem_arbiter;

    localparam int MEM_LAT    = 4;
    localparam int STARVE_MAX = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_rdata;
    logic        i_done, i_stall;
    logic        d_rd = 1'b0, d_wr = 1'b0;
    logic [15:0] d_addr = '0, d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_done, d_stall;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;

    int nComp = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    // Backing memory: preloaded pattern, read data presented exactly MEM_LAT cycles after accept.
    logic [15:0] physMem [0:65535];
    logic        rdVld  [MEM_LAT];
    logic [15:0] rdAddr [MEM_LAT];
    logic [15:0] junk = 16'h1357;

    initial begin
        for (int a = 0; a < 65536; a++) physMem[a] = 16'(a) ^ 16'hA5C3;
        for (int k = 0; k < MEM_LAT; k++) begin
            rdVld[k]  = 1'b0;
            rdAddr[k] = '0;
        end
    end

    always @(posedge clk) begin
        rdVld[0]  <= mem_en & ~mem_wr;
        rdAddr[0] <= mem_addr;
        for (int k = 1; k < MEM_LAT; k++) begin
            rdVld[k]  <= rdVld[k-1];
            rdAddr[k] <= rdAddr[k-1];
        end
        junk <= {junk[14:0], junk[15] ^ junk[13] ^ junk[12] ^ junk[10]};
        if (mem_en && mem_wr) physMem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = rdVld[MEM_LAT-1] ? physMem[rdAddr[MEM_LAT-1]] : junk;

    task automatic check(input string name, input int act, input int exp);
        nComp++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] refWr [logic [15:0]];

    function automatic logic [15:0] expRead(input logic [15:0] a);
        if (refWr.exists(a)) return refWr[a];
        return a ^ 16'hA5C3;
    endfunction

    int          mc = 0, accCyc = 0, starve = 0, win;
    bit          act = 0, own = 0, aWr = 0, lastCyc, busy, dReqM, dErrM;
    bit          eIdone, eDdone, eEn, eWr;
    logic [15:0] aAddr = '0, aWd = '0, eAddr, eWd;

    initial forever begin
        @(negedge clk);
        mc++;
        if (rst) begin
            check("reset_outputs_zero",
                  int'(|{i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
                         mem_en, mem_wr, mem_addr, mem_wdata, err}), 0);
            act    = 0;
            starve = 0;
        end else begin
            dReqM   = d_rd | d_wr;
            dErrM   = dReqM && ((d_rd && d_wr) || d_addr[0]);
            eIdone  = 0; eDdone = 0; eEn = 0; lastCyc = 0;
            eAddr   = '0; eWr = 0; eWd = '0;
            busy    = act && (mc > accCyc);
            if (busy) begin
                eAddr = aAddr; eWr = aWr; eWd = aWd;
                if (mc == accCyc + MEM_LAT) begin
                    lastCyc = 1;
                    eIdone  = !own && i_req;
                    eDdone  = own && dReqM;
                end
            end else begin
                win = -1;
                if (GUARD && starve >= STARVE_MAX && i_req) win = 0;
                else if (dReqM && !dErrM)                    win = 1;
                else if (i_req)                              win = 0;
                if (win >= 0) begin
                    eEn = 1; act = 1; accCyc = mc; own = (win == 1);
                    if (own) begin aAddr = d_addr; aWr = d_wr; aWd = d_wdata; end
                    else     begin aAddr = i_addr; aWr = 0;    aWd = '0;      end
                    eAddr = aAddr; eWr = aWr; eWd = aWd;
                    if (own && i_req) begin
                        if (starve < STARVE_MAX) starve++;
                    end else if (!own) begin
                        starve = 0;
                    end
                    if (own && aWr) refWr[aAddr] = aWd;
                end
            end
            check("err", err, dErrM);
            check("mem_en", mem_en, eEn);
            check("i_done", i_done, eIdone);
            check("d_done", d_done, eDdone);
            check("i_stall", i_stall, i_req && !eIdone);
            check("d_stall", d_stall, dReqM && !eDdone);
            if (eEn || busy) begin
                check("mem_addr", mem_addr, eAddr);
                check("mem_wr", mem_wr, eWr);
                if (eWr) check("mem_wdata", mem_wdata, eWd);
            end
            if (eIdone) check("i_rdata", i_rdata, expRead(aAddr));
            if (eDdone && !aWr) check("d_rdata", d_rdata, expRead(aAddr));
            if (lastCyc) act = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        i_req = 1'b0;
        d_rd  = 1'b0;
        d_wr  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] randAddr();
        case ($urandom_range(0, 9))
            0:       return 16'hFFFF;
            1:       return 16'hFFFE;
            default: return 16'h0100 + 16'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        int          doneAt, stallCnt, memEn0, dAt, iAt, fAcc, first, second, cnt1, cnt2, dWins, kind;
        int          iCool, dCool, dHold;
        bit          got, dn, iDn, dDn, dBad;
        logic [15:0] rdat;

        doReset();

        // Single fetch
        i_req = 1; i_addr = 16'h0010;
        doneAt = -1; stallCnt = 0; memEn0 = 0; rdat = '0;
        for (int n = 0; n < 12 && doneAt < 0; n++) begin
            @(negedge clk);
            if (n == 0) memEn0 = mem_en;
            if (i_done) begin doneAt = n; rdat = i_rdata; end
            else if (i_stall) stallCnt++;
            tick();
        end
        i_req = 0;
        check("fetch_accept_cycle0", memEn0, 1);
        check("fetch_done_cycle", doneAt, 4);
        check("fetch_rdata", rdat, 16'hA5D3);
        check("fetch_stall_cycles", stallCnt, 4);

        // Contention: data first, fetch right after
        doReset();
        i_req = 1; i_addr = 16'h0100; d_rd = 1; d_addr = 16'h0200;
        dAt = -1; iAt = -1; fAcc = -1;
        for (int n = 0; n < 16 && iAt < 0; n++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 16'h0100 && fAcc < 0) fAcc = n;
            if (d_done && dAt < 0) dAt = n;
            if (i_done) iAt = n;
            tick();
            if (dAt >= 0) d_rd = 0;
            if (iAt >= 0) i_req = 0;
        end
        i_req = 0; d_rd = 0;
        check("contend_d_done", dAt, 4);
        check("contend_fetch_accept", fAcc, 5);
        check("contend_i_done", iAt, 9);

        // Write then read back
        doReset();
        d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        first = -1; second = -1; rdat = '0;
        for (int n = 0; n < 16 && second < 0; n++) begin
            @(negedge clk);
            if (d_done) begin
                if (first < 0) first = n;
                else begin second = n; rdat = d_rdata; end
            end
            tick();
            if (first >= 0 && d_wr) begin d_wr = 0; d_rd = 1; end
        end
        d_rd = 0; d_wr = 0;
        check("wr_done_cycle", first, 4);
        check("rd_done_cycle", second, 9);
        check("readback_data", rdat, 16'hBEEF);

        // Protocol errors
        doReset();
        d_rd = 1; d_wr = 1; d_addr = 16'h0000;
        cnt1 = 0; cnt2 = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            cnt1 += int'(err);
            cnt2 += int'(mem_en);
            tick();
        end
        check("err_rdwr_cycles", cnt1, 3);
        check("err_rdwr_no_accept", cnt2, 0);
        d_wr = 0; d_addr = 16'h0003; i_req = 1; i_addr = 16'h0020;
        @(negedge clk);
        check("err_unaligned", err, 1);
        check("err_fetch_served_en", mem_en, 1);
        check("err_fetch_served_addr", mem_addr, 16'h0020);
        check("err_d_stall", d_stall, 1);
        tick();
        d_rd = 0;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (i_done) got = 1;
            tick();
        end
        i_req = 0;
        check("err_fetch_done", got, 1);

        // Reset in the middle of a data read
        doReset();
        d_rd = 1; d_addr = 16'h0200;
        @(negedge clk); tick();
        @(negedge clk); tick();
        rst = 1; d_rd = 0;
        @(negedge clk);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_outputs", int'(|{mem_en, mem_wr, mem_wdata, d_done, d_stall, d_rdata, err}), 0);
        tick();
        rst = 0;
        cnt1 = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            cnt1 += int'(d_done) + int'(mem_en);
            tick();
        end
        check("midrst_no_done", cnt1, 0);

        // Fetch under a continuous data stream
        doReset();
        i_req = 1; i_addr = 16'h0300; d_rd = 1; d_addr = 16'h0400;
        dWins = 0; fAcc = -1;
        for (int n = 0; n < 40 && fAcc < 0; n++) begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_addr == 16'h0300) fAcc = n;
                else dWins++;
            end
            dn = d_done;
            tick();
            if (dn) d_addr = d_addr + 16'd2;
        end
        d_rd = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_fetch_accept", fAcc, 15);
        check("starve_data_wins", dWins, 3);
`else
        check("strict_fetch_never", fAcc, -1);
        check("strict_data_wins", dWins, 8);
`endif
        got = 0;
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            if (i_done) got = 1;
            tick();
        end
        i_req = 0;
        check("stream_fetch_done", got, 1);

        // Randomized traffic
        doReset();
        iCool = 0; dCool = 0; dHold = 0; dBad = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            iDn = i_done;
            dDn = d_done;
            tick();
            if (rst) begin
                rst = ($urandom_range(0, 1) == 0);
                continue;
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1; idleInputs(); iCool = 0; dCool = 0;
                continue;
            end
            if (iCool > 0) iCool--;
            if (i_req) begin
                if (iDn) i_req = 0;
                else if ($urandom_range(0, 49) == 0) begin i_req = 0; iCool = MEM_LAT + 1; end
            end else if (iCool == 0 && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = randAddr();
            end
            if (dCool > 0) dCool--;
            if (d_rd || d_wr) begin
                if (dDn) begin
                    d_rd = 0; d_wr = 0;
                end else if (dBad) begin
                    if (dHold == 0) begin d_rd = 0; d_wr = 0; end
                    else dHold--;
                end else if ($urandom_range(0, 49) == 0) begin
                    d_rd = 0; d_wr = 0; dCool = MEM_LAT + 1;
                end
            end else if (dCool == 0 && $urandom_range(0, 2) == 0) begin
                kind    = $urandom_range(0, 9);
                d_addr  = randAddr() & 16'hFFFE;
                d_wdata = 16'($urandom);
                dBad    = 0;
                dHold   = $urandom_range(0, 3);
                if (kind == 0) begin
                    d_rd = 1; d_wr = 1; dBad = 1;
                end else if (kind == 1) begin
                    d_addr[0] = 1'b1; d_rd = ($urandom_range(0, 1) == 1); d_wr = !d_rd; dBad = 1;
                end else if (kind < 6) begin
                    d_rd = 1;
                end else begin
                    d_wr = 1;
                end
            end
        end
        idleInputs();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared, fixed-latency unified memory between two requesters: the instruction fetch port (read-only) and the data memory port (read/write).
- Sits between the fetch and memory stages and the backing memory.
- Returns per-port stall and done so the pipeline can freeze the IF/ID and EX/MEM registers while an access is outstanding.

Parameters:
- MEM_LAT, 4, cycles from memory accept to read data valid or write complete; must be >= 1.
- STARVE_MAX, 3, consecutive instruction-port losses before the instruction port is forced to win; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  fetch read request; held until i_done
- i_addr  in  16  fetch address
- i_rdata  out  16  fetch read data; valid when i_done
- i_done  out  1  fetch access complete (one-cycle pulse)
- i_stall  out  1  i_req & ~i_done
- d_rd  in  1  data read request; held until d_done
- d_wr  in  1  data write request; held until d_done
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_rdata  out  16  data read data; valid when d_done
- d_done  out  1  data access complete (one-cycle pulse)
- d_stall  out  1  (d_rd|d_wr) & ~d_done
- mem_en  out  1  memory command strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid MEM_LAT cycles after accept
- err  out  1  protocol error

Behaviour:
- States: IDLE, IBUSY, DBUSY. Counter width is $clog2(MEM_LAT+1).
- Reset values: state IDLE, counter 0, starvation count 0; all outputs 0 (rdata outputs 0).
- Any request mid-access is dropped: no done is issued, and the requester re-requests after reset.
- IDLE, with a request present:
  - Choose a winner; data port has priority.
  - In the same cycle, drive mem_en=1, with mem_wr/mem_addr/mem_wdata taken combinationally from the winner.
  - Latch the winner's address, write flag and wdata.
  - Load counter = MEM_LAT-1; move to IBUSY or DBUSY.
- BUSY:
  - mem_en=0; mem_addr, mem_wr and mem_wdata hold the latched values.
  - Counter decrements each cycle.
  - When the counter is 0: pulse the winner's done, drive its rdata = mem_rdata (reads), and return to IDLE next cycle.
- Latency: done fires exactly MEM_LAT cycles after the accept cycle. The earliest next accept is the cycle after done, so each access occupies MEM_LAT+1 cycles.
- Stall:
  - Losing and waiting requesters see stall=1 throughout.
  - A request that drops before its done is abandoned silently; the access still completes and its done is suppressed.
- Simultaneous i_req and data request in IDLE: data wins; the instruction port is served in the next IDLE cycle if still requesting.
- Errors:
  - err=1 (combinational) when d_rd & d_wr, or when a data request appears with d_addr[0]=1 (unaligned).
  - An errored data request is not accepted: the arbiter stays in IDLE and serves i_req if present.
- Address wrap: addresses pass through unmodified; 16'hFFFF is a legal address subject only to the alignment rule above.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating starvation counter increments each time the data port wins in IDLE while i_req=1.
  - When the counter reaches STARVE_MAX, the instruction port wins the next IDLE arbitration regardless of data requests, and the counter clears.
  - The counter also clears on any instruction win.
- Undefined: strict data priority; no starvation counter is built.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2);
  - the 16-bit address/data width constant;
  - the owner encoding (OWN_I=1'b0, OWN_D=1'b1).
- One natural sub-module: mem_arb_lat_cnt (loadable down-counter with a zero flag), reused by future cache-fill sequencing.

Test Plan:
- Single fetch, MEM_LAT=4: i_req=1, i_addr=16'h0010 at cycle 0 → mem_en=1 at cycle 0; i_done=1 at cycle 4 with i_rdata = memory[0x0010]; i_stall=1 for cycles 0-3.
- Contention: i_req and d_rd (addr 0x0200) both at cycle 0 → data accepted at cycle 0 with d_done at 4; fetch accepted at cycle 5 with i_done at 9.
- Write then read back: d_wr to 0x0040 with 16'hBEEF, then d_rd 0x0040 → d_done at 4 and 9; d_rdata=16'hBEEF at cycle 9.
- Errors:
  - d_rd=d_wr=1 → err=1, no mem_en for data, state stays IDLE.
  - d_rd to 0x0003 → err=1, not accepted.
- Reset mid-access: rst asserted at cycle 2 of a data read → state IDLE, all outputs 0, no d_done issued.
- Starvation, macro defined, STARVE_MAX=3: i_req held with a continuous data stream → fetch accepted after exactly 3 data wins.
- Starvation, macro undefined, same stimulus → fetch never accepted while the data stream continues.
